// File: rtl/vco_poly.sv
// Polyphonic oscillator: per-voice saw/rect/tri, level-scaled mix, 1st-order SDM.
// Option: define VCO_POLY_HARD_SYNC_EN to hard-sync voices 1.. to voice 0's wrap.
module vco_poly #(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 32,
  parameter int WAVE_W     = 11,
  localparam int MW        = WAVE_W + $clog2(NUM_VOICES)
) (
  input  logic                          clk_top,
  input  logic                          rst_top,
  input  logic [NUM_VOICES-1:0]         note_on,
  input  logic [NUM_VOICES-1:0]         note_off,
  input  logic [NUM_VOICES*PHASE_W-1:0] tuning_word,
  input  logic [6:0]                    WAVE_CC,
  input  logic [6:0]                    SHAPE_CC,
  input  logic [6:0]                    LEVEL_CC,
  output logic [NUM_VOICES-1:0]         voice_active,
  output logic signed [MW-1:0]          mix_out,
  output logic                          osc_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_REL
  } vstate_e;

  localparam int EW = MW + 1;
  localparam int VW = MW + 2;
  localparam int PW = MW + 8;
  localparam logic signed [VW-1:0] FS = VW'(1) << (MW - 1);

  logic [WAVE_W-1:0]        pw;
  logic signed [WAVE_W-1:0] smp_all [NUM_VOICES];
`ifdef VCO_POLY_HARD_SYNC_EN
  logic                     wrap0;
`endif

  assign pw = {SHAPE_CC, {(WAVE_W-7){1'b0}}} + WAVE_W'(1);

  genvar g;
  for (g = 0; g < NUM_VOICES; g++) begin : g_voice
    vstate_e                  state_q, state_d;
    logic [PHASE_W-1:0]       phase_q, phase_d;
    logic signed [WAVE_W-1:0] smp_q, smp_d;
    logic [PHASE_W:0]         acc;
    logic                     run;
    logic                     wrap;
    logic [WAVE_W-1:0]        saw_u;
    logic [WAVE_W-1:0]        tri_u;
    logic signed [WAVE_W-1:0] wave;

    assign run = state_q != S_IDLE;
    assign acc = {1'b0, phase_q}
               + {1'b0, tuning_word[g*PHASE_W +: PHASE_W]};

`ifdef VCO_POLY_HARD_SYNC_EN
    logic sync;
    if (g == 0) begin : g_master
      assign sync  = 1'b0;
      assign wrap0 = run && acc[PHASE_W];
    end else begin : g_slave
      assign sync = run && wrap0;
    end
    // A sync reload is not a wrap, so it never ends a release.
    assign wrap = run && acc[PHASE_W] && !sync;
`else
    assign wrap = run && acc[PHASE_W];
`endif

    always_comb begin
      state_d = state_q;
      if (note_on[g]) begin
        state_d = S_RUN;
      end else if (state_q == S_RUN && note_off[g]) begin
        state_d = S_REL;
      end else if (state_q == S_REL && wrap) begin
        state_d = S_IDLE;
      end
      phase_d = acc[PHASE_W-1:0];
      if (!run || state_d == S_IDLE) begin
        phase_d = '0;
      end
`ifdef VCO_POLY_HARD_SYNC_EN
      if (sync) begin
        phase_d = '0;
      end
`endif
    end

    always_comb begin
      saw_u = phase_q[PHASE_W-1 -: WAVE_W];
      tri_u = (saw_u[WAVE_W-1] ? ~saw_u : saw_u) << 1;
      wave  = '0;
      unique case (1'b1)
        WAVE_CC < 7'd32:
          wave = {~saw_u[WAVE_W-1], saw_u[WAVE_W-2:0]};
        WAVE_CC >= 7'd32 && WAVE_CC < 7'd64:
          wave = (saw_u < pw) ? {1'b0, {(WAVE_W-1){1'b1}}}
                              : {1'b1, {(WAVE_W-1){1'b0}}};
        WAVE_CC >= 7'd64 && WAVE_CC < 7'd96:
          wave = {~tri_u[WAVE_W-1], tri_u[WAVE_W-2:0]};
        default:
          wave = '0;
      endcase
      smp_d = run ? wave : '0;
    end

    always_ff @(posedge clk_top or negedge rst_top) begin
      if (!rst_top) begin
        state_q <= S_IDLE;
        phase_q <= '0;
        smp_q   <= '0;
      end else begin
        state_q <= state_d;
        phase_q <= phase_d;
        smp_q   <= smp_d;
      end
    end

    assign smp_all[g]      = smp_q;
    assign voice_active[g] = run;
  end

  logic signed [MW-1:0] sum_q, sum_d;
  logic signed [MW-1:0] mix_q, mix_d;
  logic signed [PW-1:0] prod;
  logic signed [EW-1:0] err_q, err_d;
  logic signed [VW-1:0] sdm_v;
  logic                 osc_q, osc_d;

  always_comb begin
    sum_d = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      sum_d = sum_d + MW'(smp_all[v]);
    end
  end

  always_comb begin
    prod  = sum_q * $signed({1'b0, LEVEL_CC});
    mix_d = MW'(prod >>> 7);
  end

  always_comb begin
    sdm_v = VW'(mix_q) + VW'(err_q);
    osc_d = ~sdm_v[VW-1];
    err_d = EW'(osc_d ? sdm_v - FS : sdm_v + FS);
  end

  always_ff @(posedge clk_top or negedge rst_top) begin
    if (!rst_top) begin
      sum_q <= '0;
      mix_q <= '0;
      err_q <= '0;
      osc_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      mix_q <= mix_d;
      err_q <= err_d;
      osc_q <= osc_d;
    end
  end

  assign mix_out = mix_q;
  assign osc_out = osc_q;

endmodule

// File: tb/tb_vco_poly.sv
// Directed self-checking bench for vco_poly (4 voices, 32-bit phase, 11-bit wave).
// Each task drives one scenario and checks hand-derived values.
module tb_vco_poly;

  logic               clk_top;
  logic               rst_top;
  logic [3:0]         note_on;
  logic [3:0]         note_off;
  logic [127:0]       tuning_word;
  logic [6:0]         WAVE_CC;
  logic [6:0]         SHAPE_CC;
  logic [6:0]         LEVEL_CC;
  logic [3:0]         voice_active;
  logic signed [12:0] mix_out;
  logic               osc_out;

  int n_tests;
  int n_fail;

  vco_poly #(
    .NUM_VOICES(4),
    .PHASE_W(32),
    .WAVE_W(11)
  ) dut (
    .clk_top(clk_top),
    .rst_top(rst_top),
    .note_on(note_on),
    .note_off(note_off),
    .tuning_word(tuning_word),
    .WAVE_CC(WAVE_CC),
    .SHAPE_CC(SHAPE_CC),
    .LEVEL_CC(LEVEL_CC),
    .voice_active(voice_active),
    .mix_out(mix_out),
    .osc_out(osc_out)
  );

  initial clk_top = 1'b0;
  always #5 clk_top = ~clk_top;

  task automatic tick();
    @(posedge clk_top);
    #1;
  endtask

  task automatic apply_reset();
    rst_top  = 1'b0;
    note_on  = '0;
    note_off = '0;
    tick();
    tick();
    rst_top = 1'b1;
  endtask

  // Level-127 mix of a saw stepping 2 codes per cycle, k cycles in.
  function automatic int saw_mix(int k);
    int s;
    s = 2 * (k % 1024) - 1024;
    return (s * 127) >>> 7;
  endfunction

  function automatic int tri_mix(int k);
    int su;
    int tu;
    su = (2 * k) % 2048;
    tu = ((su >= 1024) ? (2047 - su) : su) * 2 % 2048;
    return ((tu - 1024) * 127) >>> 7;
  endfunction

  task automatic test_reset();
    logic exp_osc;
    rst_top     = 1'b0;
    note_on     = '0;
    note_off    = '0;
    tuning_word = '0;
    WAVE_CC     = '0;
    SHAPE_CC    = '0;
    LEVEL_CC    = '0;
    tick();
    tick();
    n_tests += 3;
    if (voice_active !== 4'b0) begin
      n_fail++;
      $display("FAIL rst_active: got %b want 0000", voice_active);
    end
    if (mix_out !== 13'sd0) begin
      n_fail++;
      $display("FAIL rst_mix: got %0d want 0", mix_out);
    end
    if (osc_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_osc: got %b want 0", osc_out);
    end
    rst_top = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_osc = (i % 2 == 0);
      n_tests += 2;
      if (osc_out !== exp_osc) begin
        n_fail++;
        $display("FAIL idle_osc[%0d]: got %b want %b", i, osc_out, exp_osc);
      end
      if (mix_out !== 13'sd0) begin
        n_fail++;
        $display("FAIL idle_mix[%0d]: got %0d want 0", i, mix_out);
      end
    end
  endtask

  task automatic test_saw();
    int e;
    int mprev;
    int mexp;
    int v;
    int bad;
    logic yexp;
    logic signed [12:0] me;
    apply_reset();
    WAVE_CC     = 7'd0;
    LEVEL_CC    = 7'd127;
    tuning_word = '0;
    tuning_word[31:0] = 32'd1 << 22;
    note_on = 4'b0001;
    tick();
    note_on = '0;
    n_tests++;
    if (voice_active !== 4'b0001) begin
      n_fail++;
      $display("FAIL saw_active: got %b want 0001", voice_active);
    end
    e     = 0;
    mprev = 0;
    bad   = 0;
    for (int j = 0; j <= 1100; j++) begin
      v    = mprev + e;
      yexp = (v >= 0);
      e    = yexp ? v - 4096 : v + 4096;
      mexp = (j < 3) ? 0 : saw_mix(j - 3);
      me   = 13'(mexp);
      if (mix_out !== me || osc_out !== yexp) begin
        if (bad == 0) begin
          $display("saw first diff at %0d: mix %0d/%0d osc %b/%b",
                   j, mix_out, me, osc_out, yexp);
        end
        bad++;
      end
      if (j == 3) begin
        n_tests++;
        if (mix_out !== -13'sd1016) begin
          n_fail++;
          $display("FAIL saw_min: got %0d want -1016", mix_out);
        end
      end
      if (j == 1026) begin
        n_tests++;
        if (mix_out !== 13'sd1014) begin
          n_fail++;
          $display("FAIL saw_max: got %0d want 1014", mix_out);
        end
      end
      mprev = mexp;
      tick();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL saw_ramp_sdm: got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_rect();
    int hi;
    int lo;
    apply_reset();
    WAVE_CC     = 7'd40;
    SHAPE_CC    = 7'd32;
    LEVEL_CC    = 7'd127;
    tuning_word = '0;
    tuning_word[31:0] = 32'd1 << 21;
    note_on = 4'b0001;
    tick();
    note_on = '0;
    tick();
    tick();
    tick();
    hi = 0;
    lo = 0;
    for (int i = 0; i < 2048; i++) begin
      if (mix_out === 13'sd1015) hi++;
      if (mix_out === -13'sd1016) lo++;
      tick();
    end
    n_tests += 2;
    if (hi != 513) begin
      n_fail++;
      $display("FAIL rect_high: got %0d want 513", hi);
    end
    if (lo != 1535) begin
      n_fail++;
      $display("FAIL rect_low: got %0d want 1535", lo);
    end
  endtask

  task automatic test_tri();
    int bad;
    logic signed [12:0] me;
    apply_reset();
    WAVE_CC     = 7'd70;
    LEVEL_CC    = 7'd127;
    tuning_word = '0;
    tuning_word[31:0] = 32'd1 << 22;
    note_on = 4'b0001;
    tick();
    note_on = '0;
    tick();
    tick();
    tick();
    bad = 0;
    for (int k = 0; k < 1024; k++) begin
      me = 13'(tri_mix(k));
      if (mix_out !== me) bad++;
      if (k == 0 || k == 511 || k == 512) begin
        me = (k == 0) ? -13'sd1016 : (k == 511) ? 13'sd1012 : 13'sd1014;
        n_tests++;
        if (mix_out !== me) begin
          n_fail++;
          $display("FAIL tri_pt[%0d]: got %0d want %0d", k, mix_out, me);
        end
      end
      tick();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL tri_ramp: got %0d bad cycles want 0", bad);
    end
    WAVE_CC = 7'd96;
    repeat (4) tick();
    n_tests++;
    if (mix_out !== 13'sd0) begin
      n_fail++;
      $display("FAIL zero_96: got %0d want 0", mix_out);
    end
    WAVE_CC = 7'd127;
    repeat (4) tick();
    n_tests++;
    if (mix_out !== 13'sd0) begin
      n_fail++;
      $display("FAIL zero_127: got %0d want 0", mix_out);
    end
  endtask

  task automatic test_release();
    int bad;
    logic signed [12:0] me;
    apply_reset();
    WAVE_CC     = 7'd0;
    LEVEL_CC    = 7'd127;
    tuning_word = '0;
    tuning_word[31:0] = 32'd1 << 22;
    note_on = 4'b0001;
    tick();
    note_on = '0;
    repeat (511) tick();
    note_off = 4'b0001;
    tick();
    note_off = '0;
    n_tests++;
    if (voice_active[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rel_active: got %b want 1", voice_active[0]);
    end
    repeat (511) tick();
    n_tests++;
    if (voice_active[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rel_prewrap: got %b want 1", voice_active[0]);
    end
    tick();
    n_tests++;
    if (voice_active[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rel_idle: got %b want 0", voice_active[0]);
    end
    tick();
    tick();
    n_tests++;
    if (mix_out !== 13'sd1014) begin
      n_fail++;
      $display("FAIL rel_last: got %0d want 1014", mix_out);
    end
    tick();
    n_tests++;
    if (mix_out !== 13'sd0) begin
      n_fail++;
      $display("FAIL rel_zero: got %0d want 0", mix_out);
    end
    note_on = 4'b0001;
    tick();
    note_on = '0;
    bad = 0;
    for (int j = 1; j <= 1100; j++) begin
      if (j == 100) note_off = 4'b0001;
      if (j == 200) note_on = 4'b0001;
      tick();
      note_on  = '0;
      note_off = '0;
      me = 13'(saw_mix(j - 3));
      if (j >= 3 && mix_out !== me) bad++;
      if (voice_active[0] !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL rel_reon: got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_on_off_together();
    apply_reset();
    tuning_word = '0;
    tuning_word[31:0] = 32'd1 << 22;
    note_on  = 4'b0001;
    note_off = 4'b0001;
    tick();
    note_on  = '0;
    note_off = '0;
    n_tests++;
    if (voice_active[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL both_idle: got %b want 1", voice_active[0]);
    end
    repeat (9) tick();
    note_on  = 4'b0001;
    note_off = 4'b0001;
    tick();
    note_on  = '0;
    note_off = '0;
    repeat (1020) tick();
    n_tests++;
    if (voice_active[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL both_run: got %b want 1", voice_active[0]);
    end
  endtask

  task automatic test_all_voices();
    apply_reset();
    WAVE_CC     = 7'd40;
    SHAPE_CC    = 7'd127;
    LEVEL_CC    = 7'd127;
    tuning_word = '0;
    note_on = 4'hF;
    tick();
    note_on = '0;
    n_tests++;
    if (voice_active !== 4'hF) begin
      n_fail++;
      $display("FAIL all_active: got %b want 1111", voice_active);
    end
    tick();
    tick();
    tick();
    n_tests++;
    if (mix_out !== 13'sd4060) begin
      n_fail++;
      $display("FAIL all_max: got %0d want 4060", mix_out);
    end
    LEVEL_CC = 7'd64;
    tick();
    n_tests++;
    if (mix_out !== 13'sd2046) begin
      n_fail++;
      $display("FAIL all_lvl64: got %0d want 2046", mix_out);
    end
    LEVEL_CC = 7'd127;
    WAVE_CC  = 7'd0;
    tick();
    tick();
    tick();
    n_tests++;
    if (mix_out !== -13'sd4064) begin
      n_fail++;
      $display("FAIL all_min: got %0d want -4064", mix_out);
    end
    #2;
    rst_top = 1'b0;
    #1;
    n_tests += 3;
    if (voice_active !== 4'b0) begin
      n_fail++;
      $display("FAIL mid_rst_active: got %b want 0000", voice_active);
    end
    if (mix_out !== 13'sd0) begin
      n_fail++;
      $display("FAIL mid_rst_mix: got %0d want 0", mix_out);
    end
    if (osc_out !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_osc: got %b want 0", osc_out);
    end
    tick();
    rst_top = 1'b1;
    tick();
    n_tests += 3;
    if (voice_active !== 4'b0) begin
      n_fail++;
      $display("FAIL post_rst_active: got %b want 0000", voice_active);
    end
    if (mix_out !== 13'sd0) begin
      n_fail++;
      $display("FAIL post_rst_mix: got %0d want 0", mix_out);
    end
    if (osc_out !== 1'b1) begin
      n_fail++;
      $display("FAIL post_rst_osc: got %b want 1", osc_out);
    end
  endtask

  task automatic test_voice1_period();
    logic exp_late;
`ifdef VCO_POLY_HARD_SYNC_EN
    exp_late = 1'b1;
`else
    exp_late = 1'b0;
`endif
    apply_reset();
    WAVE_CC     = 7'd0;
    LEVEL_CC    = 7'd127;
    tuning_word = '0;
    tuning_word[31:0]  = 32'd1 << 22;
    tuning_word[63:32] = 32'd3 << 20;
    note_on = 4'b0011;
    tick();
    note_on  = '0;
    note_off = 4'b0010;
    tick();
    note_off = '0;
    repeat (1364) tick();
    n_tests++;
    if (voice_active[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL v1_e1365: got %b want 1", voice_active[1]);
    end
    tick();
    n_tests += 2;
    if (voice_active[1] !== exp_late) begin
      n_fail++;
      $display("FAIL v1_e1366: got %b want %b", voice_active[1], exp_late);
    end
    if (voice_active[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL v0_run: got %b want 1", voice_active[0]);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_saw();
    test_rect();
    test_tri();
    test_release();
    test_on_off_together();
    test_all_voices();
    test_voice1_period();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
